// File: rtl/lenet_sched_pkg.sv
// Shared types and sizes for the LeNet stage scheduler; no logic of its own.
// Stage indices name the four pipeline registers from image buffer to class-vector output.
package lenet_sched_pkg;

  typedef enum logic [1:0] {ST_IMG, ST_C2, ST_C3, ST_OUT} stage_e;

  localparam int NUM_STAGES  = 4;
  localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/lenet_stage_slot.sv
// One pipeline stage: occupancy bit plus settle counter, settled SETTLE_CYCLES cycles after load.
// A load restarts the counter even when the stage is being drained in the same cycle.
module lenet_stage_slot #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = $clog2(SETTLE_CYCLES + 2)
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_adv,
  output logic o_occ,
  output logic o_settled
);

  localparam logic [CNT_W-1:0] SAT = CNT_W'(SETTLE_CYCLES);

  logic             r_occ;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_occ <= 1'b0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_occ <= 1'b1;
      r_cnt <= '0;
    end else begin
      if (i_adv) begin
        r_occ <= 1'b0;
      end
      // Saturate so a stalled, settled stage stays settled.
      if (r_occ && (r_cnt != SAT)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_occ     = r_occ;
  assign o_settled = r_occ && (r_cnt == SAT);

endmodule

// File: rtl/lenet_stage_scheduler.sv
// Load-strobe scheduler for the 4 LeNet stage registers; input-to-out_valid latency 4+3*SETTLE_CYCLES.
// out_ready low stalls stage by stage; in_ready drops only when the image stage is full and not advancing.
module lenet_stage_scheduler
  import lenet_sched_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = $clog2(SETTLE_CYCLES + 2)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   ld_image,
  output logic                   ld_stage2,
  output logic                   ld_stage3,
  output logic                   ld_output,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  logic [NUM_STAGES-1:0]  w_occ;
  logic [NUM_STAGES-2:0]  w_settled;
  logic [NUM_STAGES-1:0]  w_adv;
  logic [NUM_STAGES-1:0]  w_load;
  logic                   w_adv_img;
  logic                   w_adv_c2;
  logic                   w_adv_c3;
  logic                   w_adv_out;
  logic                   w_in_ready;
  logic                   w_ld_image;
  logic                   r_occ_out;
  logic [FRAME_CNT_W-1:0] r_frame_cnt;

  // Advance chain resolves from the output back, so a whole stalled pipe can shift in one cycle.
  assign w_adv_out  = r_occ_out && out_ready;
  assign w_adv_c3   = w_settled[ST_C3]  && (!r_occ_out       || w_adv_out);
  assign w_adv_c2   = w_settled[ST_C2]  && (!w_occ[ST_C3]    || w_adv_c3);
  assign w_adv_img  = w_settled[ST_IMG] && (!w_occ[ST_C2]    || w_adv_c2);

  assign w_in_ready = !w_occ[ST_IMG] || w_adv_img;
  assign w_ld_image = in_valid && w_in_ready;

  assign w_adv  = {w_adv_out, w_adv_c3, w_adv_c2, w_adv_img};
  assign w_load = {w_adv_c3, w_adv_c2, w_adv_img, w_ld_image};

  for (genvar k = 0; k < NUM_STAGES - 1; k++) begin : g_slot
    lenet_stage_slot #(
      .SETTLE_CYCLES (SETTLE_CYCLES),
      .CNT_W         (CNT_W)
    ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .i_load    (w_load[k]),
      .i_adv     (w_adv[k]),
      .o_occ     (w_occ[k]),
      .o_settled (w_settled[k])
    );
  end

  assign w_occ[ST_OUT] = r_occ_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_occ_out   <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      if (w_load[ST_OUT]) begin
        r_occ_out <= 1'b1;
      end else if (w_adv[ST_OUT]) begin
        r_occ_out <= 1'b0;
      end
      if (w_adv[ST_OUT]) begin
        r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
      end
    end
  end

  assign in_ready    = w_in_ready;
  assign ld_image    = w_ld_image;
  assign ld_stage2   = w_adv_img;
  assign ld_stage3   = w_adv_c2;
  assign ld_output   = w_adv_c3;
  assign out_valid   = r_occ_out;
  assign busy        = |w_occ;
  assign frame_count = r_frame_cnt;

endmodule

// File: tb/tb_lenet_stage_scheduler.sv
// Bench for lenet_stage_scheduler: three instances (settle 4, 2, 0), directed scenarios plus
// randomized traffic checked against a timestamp-based model of the stage pipeline.
module tb_lenet_stage_scheduler;

  logic        clk;
  logic        rst  [3];
  logic        iv   [3];
  logic        ordy [3];
  logic        ir   [3];
  logic        ldi  [3];
  logic        ld2  [3];
  logic        ld3  [3];
  logic        ldo  [3];
  logic        ov   [3];
  logic        bsy  [3];
  logic [15:0] fc   [3];

  int n_pass;
  int n_total;

  // Reference model: per stage, occupied flag and first occupied cycle.
  logic [3:0]  m_occ [3];
  int          m_t   [3][4];
  int          m_cyc [3];
  logic [15:0] m_fc  [3];

  lenet_stage_scheduler #(.SETTLE_CYCLES(4)) u_dut_s4 (
    .clk(clk), .reset(rst[0]), .in_valid(iv[0]), .in_ready(ir[0]), .ld_image(ldi[0]),
    .ld_stage2(ld2[0]), .ld_stage3(ld3[0]), .ld_output(ldo[0]), .out_valid(ov[0]),
    .out_ready(ordy[0]), .busy(bsy[0]), .frame_count(fc[0]));

  lenet_stage_scheduler #(.SETTLE_CYCLES(2)) u_dut_s2 (
    .clk(clk), .reset(rst[1]), .in_valid(iv[1]), .in_ready(ir[1]), .ld_image(ldi[1]),
    .ld_stage2(ld2[1]), .ld_stage3(ld3[1]), .ld_output(ldo[1]), .out_valid(ov[1]),
    .out_ready(ordy[1]), .busy(bsy[1]), .frame_count(fc[1]));

  lenet_stage_scheduler #(.SETTLE_CYCLES(0)) u_dut_s0 (
    .clk(clk), .reset(rst[2]), .in_valid(iv[2]), .in_ready(ir[2]), .ld_image(ldi[2]),
    .ld_stage2(ld2[2]), .ld_stage3(ld3[2]), .ld_output(ldo[2]), .out_valid(ov[2]),
    .out_ready(ordy[2]), .busy(bsy[2]), .frame_count(fc[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int s_of(input int i);
    return (i == 0) ? 4 : (i == 1) ? 2 : 0;
  endfunction

  function automatic void model_clear(input int i);
    m_occ[i] = 4'b0;
    m_fc[i]  = 16'd0;
    m_cyc[i] = 0;
    for (int k = 0; k < 4; k++) m_t[i][k] = 0;
  endfunction

  // A stage may hand off once it has been occupied for at least S cycles.
  function automatic logic [3:0] model_adv(input int i, input logic r);
    logic [3:0] a;
    logic       st;
    a[3] = m_occ[i][3] && r;
    for (int k = 2; k >= 0; k--) begin
      st   = m_occ[i][k] && ((m_cyc[i] - m_t[i][k]) >= s_of(i));
      a[k] = st && (!m_occ[i][k+1] || a[k+1]);
    end
    return a;
  endfunction

  function automatic logic [22:0] model_outputs(input int i, input logic v, input logic r);
    logic [3:0] a;
    logic       rdy;
    a   = model_adv(i, r);
    rdy = !m_occ[i][0] || a[0];
    return {rdy, v && rdy, a[0], a[1], a[2], m_occ[i][3], |m_occ[i], m_fc[i]};
  endfunction

  function automatic void model_step(input int i, input logic v, input logic r, input logic rs);
    logic [3:0] a;
    logic       acc;
    if (rs) begin
      model_clear(i);
      m_cyc[i] = 1;
      return;
    end
    a   = model_adv(i, r);
    acc = v && (!m_occ[i][0] || a[0]);
    for (int k = 3; k >= 1; k--) begin
      if (a[k-1]) begin
        m_occ[i][k] = 1'b1;
        m_t[i][k]   = m_cyc[i] + 1;
      end else if (a[k]) begin
        m_occ[i][k] = 1'b0;
      end
    end
    if (acc) begin
      m_occ[i][0] = 1'b1;
      m_t[i][0]   = m_cyc[i] + 1;
    end else if (a[0]) begin
      m_occ[i][0] = 1'b0;
    end
    if (a[3]) m_fc[i] = m_fc[i] + 16'd1;
    m_cyc[i] = m_cyc[i] + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int i);
    rst[i]  = 1'b1;
    iv[i]   = 1'b0;
    ordy[i] = 1'b0;
    tick();
    tick();
    rst[i] = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; iv[i] = 1'b0; ordy[i] = 1'b0;
    end
    tick();
    tick();
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (ir[i] !== 1'b1) $display("FAIL reset_in_ready[%0d]: got %b expected 1", i, ir[i]);
      else n_pass++;
      n_total++;
      if ({ov[i], bsy[i]} !== 2'b00) $display("FAIL reset_ov_busy[%0d]: got %b expected 00", i, {ov[i], bsy[i]});
      else n_pass++;
      n_total++;
      if ({ldi[i], ld2[i], ld3[i], ldo[i]} !== 4'b0000)
        $display("FAIL reset_strobes[%0d]: got %b expected 0000", i, {ldi[i], ld2[i], ld3[i], ldo[i]});
      else n_pass++;
      n_total++;
      if (fc[i] !== 16'd0) $display("FAIL reset_frame_count[%0d]: got %0d expected 0", i, fc[i]);
      else n_pass++;
    end
    tick();
  endtask

  task automatic test_single_frame();
    logic [63:0] v_ldi, v_ld2, v_ld3, v_ldo, v_ov;
    int s;
    s = 4;
    v_ldi = '0; v_ld2 = '0; v_ld3 = '0; v_ldo = '0; v_ov = '0;
    do_reset(0);
    ordy[0] = 1'b1;
    for (int c = 0; c <= 40; c++) begin
      iv[0] = (c == 10);
      @(negedge clk);
      v_ldi[c] = ldi[0]; v_ld2[c] = ld2[0]; v_ld3[c] = ld3[0]; v_ldo[c] = ldo[0]; v_ov[c] = ov[0];
      tick();
    end
    n_total++;
    if (v_ldi !== (64'd1 << 10)) $display("FAIL single_ld_image: got %h expected %h", v_ldi, 64'd1 << 10);
    else n_pass++;
    n_total++;
    if (v_ld2 !== (64'd1 << (11 + s))) $display("FAIL single_ld_stage2: got %h expected %h", v_ld2, 64'd1 << (11 + s));
    else n_pass++;
    n_total++;
    if (v_ld3 !== (64'd1 << (12 + 2*s))) $display("FAIL single_ld_stage3: got %h expected %h", v_ld3, 64'd1 << (12 + 2*s));
    else n_pass++;
    n_total++;
    if (v_ldo !== (64'd1 << (13 + 3*s))) $display("FAIL single_ld_output: got %h expected %h", v_ldo, 64'd1 << (13 + 3*s));
    else n_pass++;
    n_total++;
    if (v_ov !== (64'd1 << (14 + 3*s))) $display("FAIL single_out_valid: got %h expected %h", v_ov, 64'd1 << (14 + 3*s));
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (fc[0] !== 16'd1) $display("FAIL single_frame_count: got %0d expected 1", fc[0]);
    else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [63:0] v_ldi, v_ldo, v_ov, e_ldi, e_ldo, e_ov;
    v_ldi = '0; v_ldo = '0; v_ov = '0; e_ldi = '0; e_ldo = '0; e_ov = '0;
    for (int j = 0; j < 8; j++) begin
      e_ldi[5*j]      = 1'b1;
      e_ldo[5*j + 15] = 1'b1;
      e_ov[5*j + 16]  = 1'b1;
    end
    do_reset(0);
    ordy[0] = 1'b1;
    for (int c = 0; c < 64; c++) begin
      iv[0] = (c <= 35);
      @(negedge clk);
      v_ldi[c] = ldi[0]; v_ldo[c] = ldo[0]; v_ov[c] = ov[0];
      tick();
    end
    n_total++;
    if (v_ldi !== e_ldi) $display("FAIL b2b_ld_image: got %h expected %h", v_ldi, e_ldi);
    else n_pass++;
    n_total++;
    if (v_ldo !== e_ldo) $display("FAIL b2b_ld_output: got %h expected %h", v_ldo, e_ldo);
    else n_pass++;
    n_total++;
    if (v_ov !== e_ov) $display("FAIL b2b_out_valid: got %h expected %h", v_ov, e_ov);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (fc[0] !== 16'd8) $display("FAIL b2b_frame_count: got %0d expected 8", fc[0]);
    else n_pass++;
    tick();
  endtask

  task automatic test_full_stall();
    int   n_acc;
    logic l_ir, l_bsy;
    logic [3:0] l_str;
    n_acc = 0; l_ir = 1'b0; l_bsy = 1'b0; l_str = '0;
    do_reset(1);
    iv[1] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ldi[1]) n_acc++;
      l_ir = ir[1]; l_bsy = bsy[1]; l_str = {ldi[1], ld2[1], ld3[1], ldo[1]};
      tick();
    end
    n_total++;
    if (n_acc != 4) $display("FAIL stall_accepted: got %0d expected 4", n_acc);
    else n_pass++;
    n_total++;
    if ({l_ir, l_bsy} !== 2'b01) $display("FAIL stall_ready_busy: got %b expected 01", {l_ir, l_bsy});
    else n_pass++;
    n_total++;
    if (l_str !== 4'b0000) $display("FAIL stall_strobes_idle: got %b expected 0000", l_str);
    else n_pass++;
    ordy[1] = 1'b1;
    @(negedge clk);
    n_total++;
    if ({ld2[1], ld3[1], ldo[1], ir[1], ldi[1], ov[1]} !== 6'b111111)
      $display("FAIL stall_release: got %b expected 111111", {ld2[1], ld3[1], ldo[1], ir[1], ldi[1], ov[1]});
    else n_pass++;
    tick();
    ordy[1] = 1'b0;
    iv[1]   = 1'b0;
    @(negedge clk);
    n_total++;
    if (fc[1] !== 16'd1) $display("FAIL stall_frame_count: got %0d expected 1", fc[1]);
    else n_pass++;
    tick();
  endtask

  task automatic test_s0_streaming();
    logic [63:0] v_ldi, v_ov, e_ldi, e_ov;
    v_ldi = '0; v_ov = '0;
    e_ldi = (64'd1 << 20) - 64'd1;
    e_ov  = e_ldi & ~((64'd1 << 4) - 64'd1);
    do_reset(2);
    iv[2] = 1'b1; ordy[2] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      v_ldi[c] = ldi[2]; v_ov[c] = ov[2];
      tick();
    end
    n_total++;
    if (v_ldi !== e_ldi) $display("FAIL s0_ld_image: got %h expected %h", v_ldi, e_ldi);
    else n_pass++;
    n_total++;
    if (v_ov !== e_ov) $display("FAIL s0_out_valid: got %h expected %h", v_ov, e_ov);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (fc[2] !== 16'd16) $display("FAIL s0_frame_count: got %0d expected 16", fc[2]);
    else n_pass++;
    tick();
    iv[2] = 1'b0; ordy[2] = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    logic seen;
    seen = 1'b0;
    do_reset(0);
    ordy[0] = 1'b1;
    for (int c = 0; c < 23; c++) begin
      iv[0] = (c <= 20);
      tick();
    end
    iv[0]  = 1'b0;
    rst[0] = 1'b1;
    @(negedge clk);
    n_total++;
    if ({bsy[0], ov[0], fc[0]} !== {1'b1, 1'b0, 16'd2})
      $display("FAIL midop_before: got busy=%b ov=%b fc=%0d expected busy=1 ov=0 fc=2", bsy[0], ov[0], fc[0]);
    else n_pass++;
    tick();
    rst[0] = 1'b0;
    @(negedge clk);
    n_total++;
    if ({bsy[0], ov[0], ir[0]} !== 3'b001)
      $display("FAIL midop_after_state: got busy/ov/in_ready=%b expected 001", {bsy[0], ov[0], ir[0]});
    else n_pass++;
    n_total++;
    if (fc[0] !== 16'd0) $display("FAIL midop_frame_count: got %0d expected 0", fc[0]);
    else n_pass++;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      seen = seen | ld2[0] | ld3[0] | ldo[0] | ov[0];
      tick();
    end
    n_total++;
    if (seen !== 1'b0) $display("FAIL midop_no_strobes: got %b expected 0", seen);
    else n_pass++;
    ordy[0] = 1'b0;
  endtask

  task automatic test_random(input int i, input int ncyc);
    logic [22:0] exp_v, act_v;
    logic        hold, r_now;
    do_reset(i);
    model_clear(i);
    hold = 1'b0;
    for (int n = 0; n < ncyc; n++) begin
      r_now = ($urandom_range(0, 149) == 0);
      if (!hold) iv[i] = ($urandom_range(0, 2) != 0);
      ordy[i] = ($urandom_range(0, 3) != 0);
      rst[i]  = r_now;
      @(negedge clk);
      exp_v = model_outputs(i, iv[i], ordy[i]);
      act_v = {ir[i], ldi[i], ld2[i], ld3[i], ldo[i], ov[i], bsy[i], fc[i]};
      n_total++;
      if (act_v !== exp_v) $display("FAIL random[%0d] cycle %0d: got %h expected %h", i, n, act_v, exp_v);
      else n_pass++;
      hold = iv[i] && !exp_v[21] && !r_now;
      @(posedge clk);
      model_step(i, iv[i], ordy[i], r_now);
      #1;
    end
    rst[i] = 1'b0; iv[i] = 1'b0; ordy[i] = 1'b0;
  endtask

  task automatic test_frame_count_wrap();
    int hit_cycle;
    hit_cycle = -1;
    do_reset(2);
    iv[2] = 1'b1; ordy[2] = 1'b1;
    for (int c = 0; c < 70000 && hit_cycle < 0; c++) begin
      @(negedge clk);
      if (fc[2] === 16'hFFFF) hit_cycle = c;
      else tick();
    end
    n_total++;
    if (hit_cycle != 65539) $display("FAIL wrap_reach_ffff: got cycle %0d expected 65539", hit_cycle);
    else n_pass++;
    tick();
    @(negedge clk);
    n_total++;
    if (fc[2] !== 16'd0) $display("FAIL wrap_to_zero: got %0d expected 0", fc[2]);
    else n_pass++;
    tick();
    iv[2] = 1'b0; ordy[2] = 1'b0;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; iv[i] = 1'b0; ordy[i] = 1'b0;
      model_clear(i);
    end
    tick();
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_full_stall();
    test_s0_streaming();
    test_reset_mid_op();
    test_random(0, 400);
    test_random(1, 400);
    test_random(2, 400);
    test_frame_count_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lenet_stage_scheduler.md
# lenet_stage_scheduler

Control-only scheduler that sequences the four pipeline registers of the LeNet accelerator: image buffer (S0), conv2 input map (S1), conv3 input map (S2) and output vector (S3). It issues per-register load strobes in place of the free-running per-clock capture. Each combinational layer group gets a programmable multicycle settle window before its result is captured. It also provides valid/ready handshakes on frame input and class-vector output, so frames pipeline with backpressure and never overwrite an unconsumed stage.

## Interface
- SETTLE_CYCLES, default 4: cycles after a stage register loads before its downstream layer group's result may be captured; legal range 0..255.
- CNT_W, default $clog2(SETTLE_CYCLES+2): settle-counter width (derived; do not override).
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all state on the edge where sampled high.
- in_valid  in  1  upstream frame on the image input is valid.
- in_ready  out  1  scheduler accepts a frame this cycle.
- ld_image  out  1  load strobe for S0; equals in_valid && in_ready.
- ld_stage2  out  1  load strobe for S1 (captures pool-1 result).
- ld_stage3  out  1  load strobe for S2 (captures pool-2 result).
- ld_output  out  1  load strobe for S3 (captures fully-connected result).
- out_valid  out  1  output vector holds an undelivered frame.
- out_ready  in  1  downstream consumes output vector.
- busy  out  1  any stage occupied.
- frame_count  out  16  frames delivered (out_valid && out_ready), wraps 0xFFFF->0.

## Operation
- Per stage k (0..3): occupancy bit occ[k]. For k = 0..2 there is also a settle counter cnt[k].
- On load of stage k: occ[k]<=1 and cnt[k]<=0. Otherwise, while occ[k] is set, cnt[k] increments and saturates at SETTLE_CYCLES.
- settled[k] = occ[k] && cnt[k]==SETTLE_CYCLES.
- adv[3] = occ[3] && out_ready.
- adv[k] (k=0..2) = settled[k] && (!occ[k+1] || adv[k+1]). Strobes: ld_stage2=adv[0], ld_stage3=adv[1], ld_output=adv[2].
- in_ready = !occ[0] || adv[0]. Combinational from state and out_ready; no comb path from in_valid.
- occ[k] next state:
  - load of k sets it.
  - else adv[k] clears it.
  - else it holds.
- Simultaneous load and advance of the same stage is a normal pipelined handoff: occ stays 1 and cnt restarts at 0.
- out_valid = occ[3]; busy = |occ.
- Upstream holds in_valid and image stable until transfer. Kernels and connect matrix must be stable while busy; changing them while busy gives undefined results, not a protocol error.
- Backpressure: with out_ready low, the stall propagates stage by stage. Settled counters hold at SETTLE_CYCLES, and no strobe fires into an occupied, non-advancing stage.
- Reset mid-operation: all in-flight frames are dropped. occ, cnt and frame_count clear to 0; no strobes in the cycle after reset.

## Timing
- Reset values: in_ready=1 (all stages empty), out_valid=0, busy=0, all ld_*=0, frame_count=0.
- Latency: with ld_image in cycle c, ld_stage2 is in c+1+S, ld_stage3 in c+2+2S, ld_output in c+3+3S, and out_valid rises in c+4+3S (S = SETTLE_CYCLES). For S=4: 16 cycles.
- Throughput: one frame per S+1 cycles with out_ready held high.
- All strobes are single-cycle per transfer. Datapath registers capture on the same edge that ends the strobe cycle.
- S=0 degenerates to a plain 4-deep valid/ready pipeline with one frame per cycle.

## Structure
- Package lenet_sched_pkg:
  - stage index enum stage_e {ST_IMG, ST_C2, ST_C3, ST_OUT}
  - NUM_STAGES=4
  - localparam FRAME_CNT_W=16
- Sub-module lenet_stage_slot: one occupancy bit plus saturating settle counter, with inputs load/advance and output settled. Instantiated for S0..S2. S3 is a bare occupancy bit in the top.
- Top lenet_stage_scheduler holds only the adv chain, handshake logic and frame_count.

## Test plan
- Single frame, S=4, out_ready=1: in_valid pulse at cycle 10 -> ld_stage2@15, ld_stage3@20, ld_output@25, out_valid@26 for 1 cycle, frame_count=1.
- Back-to-back, S=4, in_valid held 1 for 40 cycles: ld_image every 5 cycles (in_ready period 5). Delivered frames are one per 5 cycles, with no strobe into an occupied non-advancing stage.
- Full stall: S=2, out_ready=0, in_valid=1: exactly 4 frames accepted, then in_ready=0 and busy=1 with all strobes idle. Releasing out_ready for 1 cycle -> one delivery, ld_output, ld_stage3 and ld_stage2 in the same cycle, and in_ready=1 that cycle.
- S=0 streaming: in_valid=out_ready=1 -> ld_image every cycle; out_valid first at acceptance+4 cycles, then continuous.
- Reset mid-op: assert reset for 1 cycle with 3 stages occupied -> next cycle busy=0, out_valid=0, frame_count=0, in_ready=1; no output strobe for the dropped frames.
- frame_count wrap: preload via 65535 deliveries (S=0) -> the next delivery reads 0.
